// File: rtl/event_fifo_irq.sv
// Event FIFO with registered read port, occupancy count and hysteretic occupancy IRQ.
// Optional saturating dropped-write counter is built when EVENT_FIFO_OVF_CNT_EN is defined.
module event_fifo_irq #(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fifo_rst_n,
   input  logic              wr_valid,
   input  logic [DWIDTH-1:0] wr_data,
   output logic              wr_ready,
   input  logic              rd_en,
   output logic [DWIDTH-1:0] rd_data,
   output logic              rd_valid,
   output logic [AWIDTH:0]   fifo_numel,
   input  logic [AWIDTH:0]   irq_assert_thresh,
   input  logic [AWIDTH:0]   irq_deassert_thresh,
   output logic              irq,
   output logic [15:0]       ovf_cnt
);

   localparam int              DEPTH      = 1 << AWIDTH;
   localparam logic [AWIDTH:0] FULL_LEVEL = (AWIDTH+1)'(DEPTH);
   localparam logic [AWIDTH:0] ONE_LEVEL  = (AWIDTH+1)'(1);
   localparam logic [AWIDTH-1:0] PTR_ONE  = AWIDTH'(1);

   typedef enum logic {
      IRQ_IDLE,
      IRQ_ASSERTED
   } irq_state_t;

   logic [DWIDTH-1:0] mem [DEPTH];

   logic [AWIDTH-1:0] wr_ptr_reg;
   logic [AWIDTH-1:0] rd_ptr_reg;
   logic [AWIDTH:0]   numel_reg;
   logic [AWIDTH:0]   numel_next;
   logic [DWIDTH-1:0] rd_data_reg;
   logic              rd_valid_reg;
   irq_state_t        irq_state_reg;
   logic              irq_reg;

   logic not_full;
   logic not_empty;
   logic wr_accept;
   logic rd_accept;
   logic irq_disabled;
   logic irq_no_hyst;
   logic above_assert;
   logic below_deassert;

   // Handshake qualifiers depend on registered occupancy only.
   assign not_full   = (numel_reg != FULL_LEVEL);
   assign not_empty  = (numel_reg != '0);
   assign wr_accept  = wr_valid && not_full && fifo_rst_n;
   assign rd_accept  = rd_en && not_empty && fifo_rst_n;

   always_comb begin
      numel_next = numel_reg;
      case ({wr_accept, rd_accept})
         2'b10:   numel_next = numel_reg + ONE_LEVEL;
         2'b01:   numel_next = numel_reg - ONE_LEVEL;
         default: numel_next = numel_reg;
      endcase
   end

   // Storage array kept free of reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         numel_reg    <= '0;
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
      end else if (!fifo_rst_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         numel_reg    <= '0;
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         numel_reg    <= numel_next;
         rd_valid_reg <= rd_accept;
         if (wr_accept) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (rd_accept) begin
            rd_ptr_reg  <= rd_ptr_reg + PTR_ONE;
            rd_data_reg <= mem[rd_ptr_reg];
         end
      end
   end

   // IRQ decisions use registered occupancy, so irq trails fifo_numel by one cycle.
   assign irq_disabled   = (irq_assert_thresh == '0);
   assign irq_no_hyst    = (irq_deassert_thresh >= irq_assert_thresh);
   assign above_assert   = (numel_reg >= irq_assert_thresh);
   assign below_deassert = (numel_reg <= irq_deassert_thresh);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_state_reg <= IRQ_IDLE;
         irq_reg       <= 1'b0;
      end else if (!fifo_rst_n || irq_disabled) begin
         irq_state_reg <= IRQ_IDLE;
         irq_reg       <= 1'b0;
      end else if (irq_no_hyst) begin
         // Overlapping thresholds would make the FSM oscillate; follow the set level directly.
         irq_state_reg <= above_assert ? IRQ_ASSERTED : IRQ_IDLE;
         irq_reg       <= above_assert;
      end else begin
         case (irq_state_reg)
            IRQ_IDLE: begin
               if (above_assert) begin
                  irq_state_reg <= IRQ_ASSERTED;
                  irq_reg       <= 1'b1;
               end
            end
            IRQ_ASSERTED: begin
               if (below_deassert) begin
                  irq_state_reg <= IRQ_IDLE;
                  irq_reg       <= 1'b0;
               end
            end
            default: begin
               irq_state_reg <= IRQ_IDLE;
               irq_reg       <= 1'b0;
            end
         endcase
      end
   end

`ifdef EVENT_FIFO_OVF_CNT_EN
   logic [15:0] ovf_cnt_reg;

   // Any write attempt while full is dropped and counted, saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_cnt_reg <= '0;
      end else if (!fifo_rst_n) begin
         ovf_cnt_reg <= '0;
      end else if (wr_valid && !not_full && (ovf_cnt_reg != 16'hFFFF)) begin
         ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
      end
   end

   assign ovf_cnt = ovf_cnt_reg;
`else
   assign ovf_cnt = 16'd0;
`endif

   assign wr_ready   = not_full;
   assign rd_data    = rd_data_reg;
   assign rd_valid   = rd_valid_reg;
   assign fifo_numel = numel_reg;
   assign irq        = irq_reg;

endmodule

// File: tb/tb_event_fifo_irq.sv
// Directed bench for event_fifo_irq (DWIDTH=16, AWIDTH=3); expected overflow
// count follows EVENT_FIFO_OVF_CNT_EN.
module tb_event_fifo_irq;

   localparam int DW = 16;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fifo_rst_n;
   logic          wr_valid;
   logic [DW-1:0] wr_data;
   logic          wr_ready;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic [AW:0]   fifo_numel;
   logic [AW:0]   irq_assert_thresh;
   logic [AW:0]   irq_deassert_thresh;
   logic          irq;
   logic [15:0]   ovf_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int exp_ovf = 0;
`ifdef EVENT_FIFO_OVF_CNT_EN
   int ovf_en = 1;
`else
   int ovf_en = 0;
`endif

   event_fifo_irq #(.DWIDTH(DW), .AWIDTH(AW)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .fifo_rst_n          (fifo_rst_n),
      .wr_valid            (wr_valid),
      .wr_data             (wr_data),
      .wr_ready            (wr_ready),
      .rd_en               (rd_en),
      .rd_data             (rd_data),
      .rd_valid            (rd_valid),
      .fifo_numel          (fifo_numel),
      .irq_assert_thresh   (irq_assert_thresh),
      .irq_deassert_thresh (irq_deassert_thresh),
      .irq                 (irq),
      .ovf_cnt             (ovf_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; fifo_rst_n = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_en = 1'b0;
      irq_assert_thresh = '0; irq_deassert_thresh = '0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (fifo_numel !== 4'd0) begin n_err++; $display("FAIL reset_numel: got %0d expected 0", fifo_numel); end
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %0b expected 0", rd_valid); end
      n_cmp++; if (rd_data !== 16'h0) begin n_err++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %0b expected 0", irq); end
      n_cmp++; if (ovf_cnt !== 16'h0) begin n_err++; $display("FAIL reset_ovf: got %0d expected 0", ovf_cnt); end
      rst_n = 1'b1;
      tick();
      n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready: got %0b expected 1", wr_ready); end
      n_cmp++; if (fifo_numel !== 4'd0) begin n_err++; $display("FAIL reset_numel_post: got %0d expected 0", fifo_numel); end
      $display("test_reset done");
   endtask

   task automatic test_order;
      for (int i = 0; i < 6; i++) begin
         wr_valid = 1'b1; wr_data = 16'h5AA + 16'(i);
         tick();
      end
      wr_valid = 1'b0;
      n_cmp++; if (fifo_numel !== 4'd6) begin n_err++; $display("FAIL order_numel: got %0d expected 6", fifo_numel); end
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL order_no_early_valid: got %0b expected 0", rd_valid); end
      rd_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL order_valid[%0d]: got %0b expected 1", i, rd_valid); end
         n_cmp++; if (rd_data !== 16'h5AA + 16'(i)) begin n_err++; $display("FAIL order_data[%0d]: got %0h expected %0h", i, rd_data, 16'h5AA + 16'(i)); end
      end
      // FIFO now empty; a held rd_en must be ignored
      tick();
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL empty_read_valid: got %0b expected 0", rd_valid); end
      n_cmp++; if (rd_data !== 16'h5AF) begin n_err++; $display("FAIL empty_read_hold: got %0h expected 5af", rd_data); end
      n_cmp++; if (fifo_numel !== 4'd0) begin n_err++; $display("FAIL empty_read_numel: got %0d expected 0", fifo_numel); end
      rd_en = 1'b0;
      tick();
      $display("test_order done");
   endtask

   task automatic test_overflow;
      int exp_n;
      for (int i = 0; i < 10; i++) begin
         wr_valid = 1'b1; wr_data = 16'h100 + 16'(i);
         if (i >= 8) exp_ovf += ovf_en;
         tick();
         exp_n = (i + 1 > 8) ? 8 : i + 1;
         n_cmp++; if (fifo_numel !== 4'(exp_n)) begin n_err++; $display("FAIL ovf_numel[%0d]: got %0d expected %0d", i, fifo_numel, exp_n); end
         n_cmp++; if (wr_ready !== (exp_n != 8)) begin n_err++; $display("FAIL ovf_wr_ready[%0d]: got %0b expected %0b", i, wr_ready, exp_n != 8); end
      end
      wr_valid = 1'b0;
      n_cmp++; if (ovf_cnt !== 16'(exp_ovf)) begin n_err++; $display("FAIL ovf_count: got %0d expected %0d", ovf_cnt, exp_ovf); end
      rd_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_cmp++; if (rd_data !== 16'h100 + 16'(i) || rd_valid !== 1'b1) begin n_err++; $display("FAIL ovf_drain[%0d]: got %0h/%0b expected %0h/1", i, rd_data, rd_valid, 16'h100 + 16'(i)); end
      end
      rd_en = 1'b0;
      tick();
      n_cmp++; if (fifo_numel !== 4'd0) begin n_err++; $display("FAIL ovf_drained_numel: got %0d expected 0", fifo_numel); end
      $display("test_overflow done");
   endtask

   task automatic test_simultaneous;
      for (int i = 0; i < 8; i++) begin
         wr_valid = 1'b1; wr_data = 16'h200 + 16'(i);
         tick();
      end
      wr_valid = 1'b1; wr_data = 16'h2FF; rd_en = 1'b1;
      exp_ovf += ovf_en;
      tick();
      wr_valid = 1'b0; rd_en = 1'b0;
      n_cmp++; if (fifo_numel !== 4'd7) begin n_err++; $display("FAIL full_both_numel: got %0d expected 7", fifo_numel); end
      n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 16'h200) begin n_err++; $display("FAIL full_both_read: got %0h/%0b expected 200/1", rd_data, rd_valid); end
      n_cmp++; if (ovf_cnt !== 16'(exp_ovf)) begin n_err++; $display("FAIL full_both_ovf: got %0d expected %0d", ovf_cnt, exp_ovf); end
      rd_en = 1'b1;
      for (int i = 1; i < 8; i++) begin
         tick();
         n_cmp++; if (rd_data !== 16'h200 + 16'(i)) begin n_err++; $display("FAIL full_both_drain[%0d]: got %0h expected %0h", i, rd_data, 16'h200 + 16'(i)); end
      end
      rd_en = 1'b0;
      tick();
      n_cmp++; if (fifo_numel !== 4'd0) begin n_err++; $display("FAIL full_both_empty: got %0d expected 0", fifo_numel); end
      wr_valid = 1'b1; wr_data = 16'h333; rd_en = 1'b1;
      tick();
      wr_valid = 1'b0; rd_en = 1'b0;
      n_cmp++; if (fifo_numel !== 4'd1) begin n_err++; $display("FAIL empty_both_numel: got %0d expected 1", fifo_numel); end
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL empty_both_valid: got %0b expected 0", rd_valid); end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      n_cmp++; if (rd_data !== 16'h333 || rd_valid !== 1'b1) begin n_err++; $display("FAIL empty_both_word: got %0h/%0b expected 333/1", rd_data, rd_valid); end
      tick();
      $display("test_simultaneous done");
   endtask

   task automatic test_irq_hyst;
      irq_assert_thresh = 4'd6; irq_deassert_thresh = 4'd2;
      for (int i = 0; i < 6; i++) begin
         wr_valid = 1'b1; wr_data = 16'h600 + 16'(i);
         tick();
         n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL hyst_fill_irq[%0d]: got %0b expected 0", i, irq); end
      end
      wr_valid = 1'b0;
      tick();
      n_cmp++; if (irq !== 1'b1 || fifo_numel !== 4'd6) begin n_err++; $display("FAIL hyst_set: got irq=%0b numel=%0d expected irq=1 numel=6", irq, fifo_numel); end
      rd_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL hyst_hold[%0d]: got %0b expected 1 (numel=%0d)", i, irq, fifo_numel); end
      end
      rd_en = 1'b0;
      n_cmp++; if (fifo_numel !== 4'd2) begin n_err++; $display("FAIL hyst_numel2: got %0d expected 2", fifo_numel); end
      tick();
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL hyst_clear: got %0b expected 0", irq); end
      $display("test_irq_hyst done");
   endtask

   task automatic test_soft_clear;
      irq_assert_thresh = 4'd4; irq_deassert_thresh = 4'd1;
      for (int i = 0; i < 3; i++) begin
         wr_valid = 1'b1; wr_data = 16'h700 + 16'(i);
         tick();
      end
      wr_valid = 1'b0;
      tick();
      n_cmp++; if (fifo_numel !== 4'd5 || irq !== 1'b1) begin n_err++; $display("FAIL clr_pre: got numel=%0d irq=%0b expected 5/1", fifo_numel, irq); end
      fifo_rst_n = 1'b0; wr_valid = 1'b1; wr_data = 16'h7EE; rd_en = 1'b1;
      tick();
      fifo_rst_n = 1'b1; wr_valid = 1'b0; rd_en = 1'b0;
      exp_ovf = 0;
      n_cmp++; if (fifo_numel !== 4'd0) begin n_err++; $display("FAIL clr_numel: got %0d expected 0", fifo_numel); end
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL clr_irq: got %0b expected 0", irq); end
      n_cmp++; if (ovf_cnt !== 16'h0) begin n_err++; $display("FAIL clr_ovf: got %0d expected 0", ovf_cnt); end
      n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 16'h0) begin n_err++; $display("FAIL clr_rd: got %0h/%0b expected 0/0", rd_data, rd_valid); end
      n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL clr_wr_ready: got %0b expected 1", wr_ready); end
      wr_valid = 1'b1; wr_data = 16'h4C4;
      tick();
      wr_valid = 1'b0; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      n_cmp++; if (rd_data !== 16'h4C4 || rd_valid !== 1'b1) begin n_err++; $display("FAIL clr_new_word: got %0h/%0b expected 4c4/1", rd_data, rd_valid); end
      tick();
      n_cmp++; if (fifo_numel !== 4'd0) begin n_err++; $display("FAIL clr_final_numel: got %0d expected 0", fifo_numel); end
      $display("test_soft_clear done");
   endtask

   task automatic test_no_hyst;
      int exp_n = 0;
      int prev_n;
      irq_assert_thresh = 4'd3; irq_deassert_thresh = 4'd5;
      for (int step = 0; step < 10; step++) begin
         prev_n = exp_n;
         if (step < 5) begin
            wr_valid = 1'b1; wr_data = 16'h800 + 16'(step); rd_en = 1'b0; exp_n++;
         end else begin
            wr_valid = 1'b0; rd_en = 1'b1; exp_n--;
         end
         tick();
         n_cmp++; if (irq !== (prev_n >= 3)) begin n_err++; $display("FAIL nohyst_irq[%0d]: got %0b expected %0b (numel %0d->%0d)", step, irq, prev_n >= 3, prev_n, exp_n); end
      end
      wr_valid = 1'b0; rd_en = 1'b0;
      tick();
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL nohyst_idle_irq: got %0b expected 0", irq); end
      irq_assert_thresh = 4'd0; irq_deassert_thresh = 4'd0;
      for (int i = 0; i < 8; i++) begin
         wr_valid = 1'b1; wr_data = 16'h900 + 16'(i);
         tick();
         n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL disabled_irq[%0d]: got %0b expected 0", i, irq); end
      end
      wr_valid = 1'b0;
      tick();
      n_cmp++; if (irq !== 1'b0 || fifo_numel !== 4'd8 || wr_ready !== 1'b0) begin n_err++; $display("FAIL disabled_full: got irq=%0b numel=%0d wr_ready=%0b expected 0/8/0", irq, fifo_numel, wr_ready); end
      n_cmp++; if (ovf_cnt !== 16'(exp_ovf)) begin n_err++; $display("FAIL final_ovf: got %0d expected %0d", ovf_cnt, exp_ovf); end
      $display("test_no_hyst done");
   endtask

   initial begin
      test_reset();
      test_order();
      test_overflow();
      test_simultaneous();
      test_irq_hyst();
      test_soft_clear();
      test_no_hyst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/event_fifo_irq.md
EVENT_FIFO_IRQ -- requirements
Module: event_fifo_irq

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, event word width in bits.
REQ-002 SHALL have parameter AWIDTH, default 8, address width; depth = 2**AWIDTH words.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port fifo_rst_n  input  1  synchronous active-low soft clear.
REQ-006 SHALL have port wr_valid  input  1  write request.
REQ-007 SHALL have port wr_data  input  DWIDTH  write word.
REQ-008 SHALL have port wr_ready  output  1  high when not full.
REQ-009 SHALL have port rd_en  input  1  read request.
REQ-010 SHALL have port rd_data  output  DWIDTH  registered read word.
REQ-011 SHALL have port rd_valid  output  1  rd_data valid strobe.
REQ-012 SHALL have port fifo_numel  output  AWIDTH+1  current occupancy.
REQ-013 SHALL have port irq_assert_thresh  input  AWIDTH+1  IRQ set level.
REQ-014 SHALL have port irq_deassert_thresh  input  AWIDTH+1  IRQ clear level.
REQ-015 SHALL have port irq  output  1  registered hysteretic interrupt.
REQ-016 SHALL have port ovf_cnt  output  16  dropped-write count.

Function
REQ-017 SHALL accept a write on a clock edge with wr_valid=1 and wr_ready=1; wr_ready = (fifo_numel != 2**AWIDTH), from registered state only.
REQ-018 SHALL, for rd_en=1 with fifo_numel != 0, present the oldest word on rd_data with rd_valid=1 exactly one cycle later; rd_valid SHALL be a single-cycle pulse per accepted read.
REQ-019 SHALL ignore rd_en when empty: rd_valid stays 0, rd_data holds its last value, pointers unchanged.
REQ-020 SHALL, on simultaneous accepted read and write, keep fifo_numel unchanged; when empty, write accepted and read ignored; when full, read accepted and write rejected (wr_ready=0 that cycle).
REQ-021 SHALL wrap read/write pointers modulo 2**AWIDTH; fifo_numel SHALL range 0..2**AWIDTH inclusive and never wrap.
REQ-022 SHALL count a write attempt with wr_valid=1 and wr_ready=0 as an overflow; the word is dropped, FIFO contents unchanged.
REQ-023 SHALL implement IRQ FSM with states IDLE (irq=0) and ASSERTED (irq=1), evaluated on registered fifo_numel, transition visible on irq one cycle after fifo_numel changes.
REQ-024 SHALL move IDLE->ASSERTED when fifo_numel >= irq_assert_thresh, and ASSERTED->IDLE when fifo_numel <= irq_deassert_thresh.
REQ-025 SHALL, when irq_deassert_thresh >= irq_assert_thresh, degrade to irq = (fifo_numel >= irq_assert_thresh) registered, with no hysteresis.
REQ-026 SHALL treat irq_assert_thresh = 0 as IRQ disabled: FSM forced to IDLE.
REQ-027 SHALL saturate ovf_cnt at 16'hFFFF.

Reset
REQ-028 SHALL, on rst_n=0, asynchronously clear pointers, fifo_numel=0, rd_data=0, rd_valid=0, irq=0 (IDLE), ovf_cnt=0; wr_ready=1 after release.
REQ-029 SHALL, on fifo_rst_n=0 at a clock edge, apply the same clear synchronously, taking priority over simultaneous read/write, including mid-burst; FIFO RAM contents need not be cleared.

Configuration
REQ-030 SHALL compile the overflow counter only when macro EVENT_FIFO_OVF_CNT_EN is defined; when undefined, ovf_cnt SHALL be tied to 0 and dropped writes remain silently discarded.

Verification
REQ-031 SHALL cover: DWIDTH=16, AWIDTH=3, write 'h5AA..'h5AF then 6 reads -> rd_data 'h5AA..'h5AF in order, each rd_valid one cycle after rd_en.
REQ-032 SHALL cover: AWIDTH=3, 10 writes from empty -> fifo_numel=8, wr_ready=0 after 8th, ovf_cnt=2 (macro on) or 0 (macro off).
REQ-033 SHALL cover: assert_thresh=6, deassert_thresh=2; fill to 6 -> irq=1 next cycle; read to 3 -> irq stays 1; read to 2 -> irq=0 next cycle.
REQ-034 SHALL cover: full FIFO, simultaneous rd_en and wr_valid -> numel drops to 7, write dropped; empty FIFO, both -> numel=1, rd_valid=0.
REQ-035 SHALL cover: 5 words stored, irq=1, pulse fifo_rst_n low one cycle -> numel=0, irq=0, ovf_cnt=0 next cycle; subsequent write/read returns new word.
REQ-036 SHALL cover: assert_thresh=3, deassert_thresh=5 -> irq tracks numel>=3 without hysteresis; assert_thresh=0 -> irq never set at full.
